// File: rtl/fpu_addsub_pipe_if.sv
// Operand/result handshake bundle for the multi-cycle floating-point add/subtract unit.
interface fpu_addsub_pipe_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_out;
  logic [3:0]   status_out;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, data_out, status_out
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, data_out, status_out
  );
endinterface

// File: rtl/fpu_addsub_pipe.sv
// Multi-cycle floating-point add/subtract: bit-serial align and normalise, round-to-nearest-even.
// One operation in flight; operands are swapped at accept so the larger magnitude is always "big".
module fpu_addsub_pipe #(
  parameter int EXP_W  = 6,
  parameter int MANT_W = 25,
  parameter int W      = 1 + EXP_W + MANT_W
) (
  input  logic             clk,
  input  logic             reset,
  fpu_addsub_pipe_if.slave bus
);
  // Working significand: {hidden, fraction, guard, round, sticky}.
  localparam int E      = MANT_W + 4;
  localparam int MAX_SH = MANT_W + 3;
  localparam int CNT_W  = $clog2(MAX_SH + 1);
  localparam int XW     = EXP_W + 2;
  localparam int MW2    = MANT_W + 2;
  localparam logic signed [XW-1:0] EXP_MAX = XW'((2 ** EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_MIN = XW'(1);

  localparam logic [3:0] ST_EXACT = 4'b1000;
  localparam logic [3:0] ST_OVF   = 4'b0100;
  localparam logic [3:0] ST_UNF   = 4'b0010;
  localparam logic [3:0] ST_INX   = 4'b0001;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [E-1:0]          big_sig, small_sig;
  logic [E:0]            sig_r;
  logic                  big_sign, eff_sub;
  logic signed [XW-1:0]  exp_r;
  logic [CNT_W-1:0]      shift_cnt;
  logic [W-1:0]          data_r;
  logic [3:0]            status_r;

  // Operand decode; a zero exponent forces a zero significand whatever the fraction holds.
  logic [EXP_W-1:0]  a_exp, b_exp, ld_big_exp, ld_small_exp, exp_diff;
  logic [MANT_W-1:0] a_fm, b_fm;
  logic              a_nz, b_nz, b_sign_eff, a_ge;
  logic              ld_big_sign, ld_small_sign, ld_small_nz;
  logic [E-1:0]      ld_big_sig, ld_small_sig;
  logic [CNT_W-1:0]  ld_shift;

  assign a_exp      = bus.a[W-2 -: EXP_W];
  assign b_exp      = bus.b[W-2 -: EXP_W];
  assign a_nz       = |a_exp;
  assign b_nz       = |b_exp;
  assign a_fm       = bus.a[MANT_W-1:0] & {MANT_W{a_nz}};
  assign b_fm       = bus.b[MANT_W-1:0] & {MANT_W{b_nz}};
  assign b_sign_eff = bus.b[W-1] ^ (bus.op == 2'b01);
  assign a_ge       = {a_exp, a_fm} >= {b_exp, b_fm};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ld_big_sign   = bus.a[W-1];
    ld_big_exp    = a_exp;
    ld_big_sig    = {a_nz, a_fm, 3'b000};
    ld_small_sign = b_sign_eff;
    ld_small_exp  = b_exp;
    ld_small_sig  = {b_nz, b_fm, 3'b000};
    ld_small_nz   = b_nz;
    if (!a_ge) begin
      ld_big_sign   = b_sign_eff;
      ld_big_exp    = b_exp;
      ld_big_sig    = {b_nz, b_fm, 3'b000};
      ld_small_sign = bus.a[W-1];
      ld_small_exp  = a_exp;
      ld_small_sig  = {a_nz, a_fm, 3'b000};
      ld_small_nz   = a_nz;
    end
    exp_diff = ld_big_exp - ld_small_exp;
    if (!ld_small_nz)
      ld_shift = '0;
    else if (32'(exp_diff) > MAX_SH)
      ld_shift = CNT_W'(MAX_SH);
    else
      ld_shift = CNT_W'(exp_diff);
  end

  logic [E:0] sum;
  assign sum = eff_sub ? ({1'b0, big_sig} - {1'b0, small_sig})
                       : ({1'b0, big_sig} + {1'b0, small_sig});

  // Rounding: LSB/guard/round-or-sticky decide; a carry out of the mantissa bumps the exponent.
  logic [MANT_W:0]      m;
  logic                 g, rs, rnd_up;
  logic [MANT_W+1:0]    m_rnd;
  logic signed [XW-1:0] exp_rnd;
  logic [MANT_W-1:0]    frac_rnd;
  logic [W-1:0]         rnd_data;
  logic [3:0]           rnd_status;

  assign m        = sig_r[E-1:3];
  assign g        = sig_r[2];
  assign rs       = |sig_r[1:0];
  assign rnd_up   = g & (rs | m[0]);
  assign m_rnd    = {1'b0, m} + MW2'(rnd_up);
  assign exp_rnd  = exp_r + XW'(m_rnd[MANT_W+1]);
  assign frac_rnd = m_rnd[MANT_W+1] ? m_rnd[MANT_W:1] : m_rnd[MANT_W-1:0];

  always_comb begin
    rnd_data   = {big_sign, exp_rnd[EXP_W-1:0], frac_rnd};
    rnd_status = (g | rs) ? ST_INX : ST_EXACT;
    if (sig_r[E-1:0] == '0) begin
      rnd_data   = '0;
      rnd_status = ST_EXACT;
    end else if (exp_rnd > EXP_MAX) begin
      rnd_data   = {big_sign, {EXP_W{1'b1}}, {MANT_W{1'b1}}};
      rnd_status = ST_OVF | ST_INX;
    end else if (exp_rnd < EXP_MIN) begin
      rnd_data   = {big_sign, {(W-1){1'b0}}};
      rnd_status = ST_UNF | ST_INX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = bus.op[1] ? S_DONE : S_ALIGN;
      S_ALIGN: if (shift_cnt <= CNT_W'(1)) state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      // Leave once the value is normalised, or will be after this cycle's shift.
      S_NORM:  if (sig_r[E] || (sig_r[E-1:0] == '0) || sig_r[E-1] || sig_r[E-2])
                 state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      big_sig   <= '0;
      small_sig <= '0;
      sig_r     <= '0;
      big_sign  <= 1'b0;
      eff_sub   <= 1'b0;
      exp_r     <= '0;
      shift_cnt <= '0;
      data_r    <= '0;
      status_r  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          big_sig   <= ld_big_sig;
          small_sig <= ld_small_sig;
          big_sign  <= ld_big_sign;
          eff_sub   <= ld_big_sign ^ ld_small_sign;
          exp_r     <= XW'(ld_big_exp);
          shift_cnt <= ld_shift;
          if (bus.op[1]) begin
            data_r   <= '0;
            status_r <= '0;
          end
        end
        S_ALIGN: if (shift_cnt != '0) begin
          small_sig <= {1'b0, small_sig[E-1:2], |small_sig[1:0]};
          shift_cnt <= shift_cnt - CNT_W'(1);
        end
        S_ADD: sig_r <= sum;
        S_NORM: begin
          if (sig_r[E]) begin
            sig_r <= {1'b0, sig_r[E:2], |sig_r[1:0]};
            exp_r <= exp_r + XW'(1);
          end else if ((sig_r[E-1:0] != '0) && !sig_r[E-1]) begin
            sig_r <= sig_r << 1;
            exp_r <= exp_r - XW'(1);
          end
        end
        S_ROUND: begin
          data_r   <= rnd_data;
          status_r <= rnd_status;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.data_out   = data_r;
  assign bus.status_out = status_r;
endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed bench for fpu_addsub_pipe: default 6/25 format and an 8/23 IEEE-single-like instance.
module tb_fpu_addsub_pipe;
  logic clk = 1'b0;
  logic reset;
  int   total;
  int   bad;

  always #5 clk = ~clk;

  fpu_addsub_pipe_if #(.W(32)) bus_s ();
  fpu_addsub_pipe_if #(.W(32)) bus_i ();

  fpu_addsub_pipe dut_s (.clk(clk), .reset(reset), .bus(bus_s));
  fpu_addsub_pipe #(.EXP_W(8), .MANT_W(23)) dut_i (.clk(clk), .reset(reset), .bus(bus_i));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
    end
  endtask

  // Issue one operation from an idle unit; returns the result and accept-to-valid latency in edges.
  task automatic do_op(input bit ieee, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input bit hold,
                       output logic [31:0] res, output logic [3:0] st, output int lat);
    if (ieee) begin
      bus_i.a = a; bus_i.b = b; bus_i.op = op; bus_i.in_valid = 1'b1; bus_i.out_ready = !hold;
    end else begin
      bus_s.a = a; bus_s.b = b; bus_s.op = op; bus_s.in_valid = 1'b1; bus_s.out_ready = !hold;
    end
    @(posedge clk); #1;
    bus_i.in_valid = 1'b0;
    bus_s.in_valid = 1'b0;
    lat = 1;
    while (!(ieee ? bus_i.out_valid : bus_s.out_valid) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) check("timeout", 32'd0, 32'd1);
    res = ieee ? bus_i.data_out : bus_s.data_out;
    st  = ieee ? bus_i.status_out : bus_s.status_out;
    if (!hold) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] res;
  logic [3:0]  st;
  int          lat;
  logic        stable;

  initial begin
    total = 0;
    bad   = 0;
    bus_s.in_valid = 1'b0; bus_s.out_ready = 1'b1; bus_s.a = '0; bus_s.b = '0; bus_s.op = '0;
    bus_i.in_valid = 1'b0; bus_i.out_ready = 1'b1; bus_i.a = '0; bus_i.b = '0; bus_i.op = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus_s.in_ready, 1);
    check("rst_out_valid", bus_s.out_valid, 0);
    check("rst_data", bus_s.data_out, 0);
    check("rst_status", bus_s.status_out, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    do_op(0, 32'h3E000000, 32'h3E000000, 2'b00, 0, res, st, lat);
    check("one_plus_one", res, 32'h40000000);
    check("one_plus_one_st", st, 4'b1000);

    do_op(0, 32'h3E000000, 32'h3E000000, 2'b01, 0, res, st, lat);
    check("one_minus_one", res, 32'h00000000);
    check("one_minus_one_st", st, 4'b1000);

    do_op(0, 32'h3E000000, 32'hBE000000, 2'b00, 0, res, st, lat);
    check("one_plus_neg_one", res, 32'h00000000);
    check("one_plus_neg_one_st", st, 4'b1000);

    do_op(0, 32'h3E000000, 32'h0A000000, 2'b00, 0, res, st, lat);
    check("tie_even", res, 32'h3E000000);
    check("tie_even_st", st, 4'b0001);
    check("tie_lat_min", lat >= 28, 1);
    check("tie_lat_max", lat <= 60, 1);

    do_op(0, 32'h3E000001, 32'h0A000000, 2'b00, 0, res, st, lat);
    check("tie_odd_up", res, 32'h3E000002);
    check("tie_odd_up_st", st, 4'b0001);

    do_op(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'b00, 0, res, st, lat);
    check("overflow", res, 32'h7FFFFFFF);
    check("overflow_st", st, 4'b0101);

    do_op(0, {1'b0, 6'd1, 25'd1}, {1'b0, 6'd1, 25'd0}, 2'b01, 0, res, st, lat);
    check("underflow", res, 32'h00000000);
    check("underflow_st", st, 4'b0011);
    check("underflow_lat_max", lat <= 60, 1);

    do_op(0, 32'h00000000, 32'h3E000000, 2'b01, 0, res, st, lat);
    check("zero_minus_one", res, 32'hBE000000);
    check("zero_minus_one_st", st, 4'b1000);

    do_op(0, 32'h3E000000, 32'h3E000000, 2'b10, 0, res, st, lat);
    check("reserved_data", res, 32'h00000000);
    check("reserved_st", st, 4'b0000);
    check("reserved_lat", lat, 1);

    // Back-pressure: result must hold and a new request must be ignored.
    do_op(0, 32'h3E000000, 32'h3E000000, 2'b00, 1, res, st, lat);
    check("hold_first", res, 32'h40000000);
    bus_s.a = 32'h7FFFFFFF; bus_s.b = 32'h7FFFFFFF; bus_s.op = 2'b00; bus_s.in_valid = 1'b1;
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus_s.data_out !== 32'h40000000 || bus_s.status_out !== 4'b1000 ||
          bus_s.in_ready !== 1'b0 || bus_s.out_valid !== 1'b1)
        stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    check("hold_in_ready", bus_s.in_ready, 0);
    bus_s.in_valid  = 1'b0;
    bus_s.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", bus_s.in_ready, 1);
    check("release_out_valid", bus_s.out_valid, 0);
    check("release_data_kept", bus_s.data_out, 32'h40000000);

    // Reset in the middle of a long alignment.
    bus_s.a = 32'h3E000000; bus_s.b = 32'h0A000000; bus_s.op = 2'b00; bus_s.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_s.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_busy", bus_s.in_ready, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", bus_s.out_valid, 0);
    check("mid_rst_in_ready", bus_s.in_ready, 1);
    check("mid_rst_data", bus_s.data_out, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    do_op(0, 32'h3E000000, 32'h3E000000, 2'b00, 0, res, st, lat);
    check("post_rst_add", res, 32'h40000000);
    check("post_rst_add_st", st, 4'b1000);

    // IEEE-single-like instance.
    do_op(1, 32'h3F800000, 32'h3F800000, 2'b00, 0, res, st, lat);
    check("ieee_one_plus_one", res, 32'h40000000);
    check("ieee_one_plus_one_st", st, 4'b1000);

    do_op(1, 32'h3F800000, 32'h3F800000, 2'b01, 0, res, st, lat);
    check("ieee_one_minus_one", res, 32'h00000000);
    check("ieee_one_minus_one_st", st, 4'b1000);

    do_op(1, 32'h3F800000, 32'hBF800000, 2'b00, 0, res, st, lat);
    check("ieee_one_plus_neg_one", res, 32'h00000000);
    check("ieee_one_plus_neg_one_st", st, 4'b1000);

    do_op(1, 32'h3F800000, 32'h33800000, 2'b00, 0, res, st, lat);
    check("ieee_tie_even", res, 32'h3F800000);
    check("ieee_tie_even_st", st, 4'b0001);
    check("ieee_tie_lat_min", lat >= 26, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
